// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that forwards changed or periodically refreshed bytes from
// four sources into a UART TX FIFO, one write strobe followed by a fixed idle gap.

module uart_tx_src_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       capture,
    input  logic       refresh_set,
    output logic       pending
);
    logic [7:0] last_sent;
    logic       refresh_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sent   <= 8'h00;
            refresh_req <= 1'b0;
        end else begin
            if (capture) last_sent <= data;
            // a refresh wrap beats the clear from a same-cycle grant
            if (refresh_set)  refresh_req <= 1'b1;
            else if (capture) refresh_req <= 1'b0;
        end
    end

    assign pending = (data != last_sent) || refresh_req;
endmodule

module uart_tx_scheduler #(
    parameter int REFRESH_CYCLES = 1_000_000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_game_state_sel,
    input  logic [7:0] data_gloves_control,
    input  logic [7:0] data_mouse_control,
    input  logic [7:0] data_score_control,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic       busy
);
    localparam int NUM_SRC = 4;
    localparam int CNT_W   = $clog2(REFRESH_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

    state_t                      state, state_nx;
    logic [NUM_SRC-1:0][7:0]     src_data;
    logic [NUM_SRC-1:0]          pending;
    logic [1:0]                  rr_ptr, sel, grant, idx;
    logic                        grant_vld, take;
    logic [7:0]                  gap_cnt;
    logic [CNT_W-1:0]            ref_cnt;
    logic                        ref_wrap;

    assign src_data = {data_score_control, data_mouse_control,
                       data_gloves_control, data_game_state_sel};

    assign ref_wrap = (ref_cnt == CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           ref_cnt <= '0;
        else if (ref_wrap) ref_cnt <= '0;
        else               ref_cnt <= ref_cnt + CNT_W'(1);
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        uart_tx_src_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .data        (src_data[i]),
            .capture     (take && (grant == 2'(i))),
            .refresh_set (ref_wrap),
            .pending     (pending[i])
        );
    end

    // scan from the farthest offset down so the nearest pending source at/after rr_ptr wins
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = rr_ptr + 2'(k);
            if (pending[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign take = (state == IDLE) && grant_vld && !tx_full;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = SEND;
            SEND:    state_nx = GAP;
            GAP:     if (gap_cnt == 8'(GAP_CYCLES - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            sel     <= '0;
            w_data  <= 8'h00;
            gap_cnt <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                w_data <= src_data[grant];
                sel    <= grant;
            end
            if (state == SEND) begin
                rr_ptr  <= sel + 2'd1;
                gap_cnt <= '0;
            end
            if (state == GAP) gap_cnt <= gap_cnt + 8'd1;
        end
    end

    // strobe is decoded from state so an async reset kills it immediately
    assign wr_uart = (state == SEND);
    assign busy    = (state != IDLE);
endmodule
